// File: rtl/qspi_read_seq.sv
// qspi_read_seq: Quad-SPI 0xEB (Fast Read Quad I/O) read sequencer.
// Drives the spiss/spiss2/spiout/spiz0/spiz1 pin bundle and streams received
// bytes out with a one-cycle valid strobe, then holds a chip-select gap.
// Optional build macro: QSPI_XIP_EN (continuous-read mode, CMD skipped after
// the first completed transaction).
module qspi_read_seq #(
    parameter logic [7:0] CMD_BYTE  = 8'hEB,
    parameter int         DUMMY_CYC = 4,
    parameter int         CSH_CYC   = 2,
    parameter int         LEN_W     = 8
) (
    input  logic             spiclk,
    input  logic             rstn,
    input  logic             req,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             done,
    output logic             spiss,
    output logic             spiss2,
    output logic [3:0]       spiout,
    input  logic [3:0]       spiin,
    output logic             spiz0,
    output logic             spiz1
);

`ifdef QSPI_XIP_EN
    localparam logic [7:0] MODE_BYTE = 8'hA0;
`else
    localparam logic [7:0] MODE_BYTE = 8'hFF;
`endif

    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYC - 1);
    localparam logic [3:0] CSH_LAST   = 4'(CSH_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, PRE, CMD, ADDR, MODE, DUMMY, DATA, POST, GAP
    } state_t;

    state_t           state, state_d;
    logic [3:0]       cnt, cnt_d;       // cycle index within the current phase
    logic [LEN_W-1:0] bcnt, bcnt_d;     // bytes remaining minus one
    logic [23:0]      addr_q;
    logic [3:0]       hi_q;             // high nibble of the byte being received
    logic             xip_active;

    logic             busy_d, done_d, spiss_d, spiss2_d, spiz0_d, spiz1_d;
    logic [3:0]       spiout_d;
    logic [2:0]       bidx;

    // State, phase counter, byte counter and address latch
    always_ff @(posedge spiclk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            bcnt   <= '0;
            addr_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            bcnt  <= bcnt_d;
            if (state == IDLE && req)
                addr_q <= addr;
        end
    end

`ifdef QSPI_XIP_EN
    // Continuous-read mode becomes active once a full transaction has closed
    always_ff @(posedge spiclk or negedge rstn) begin
        if (!rstn)
            xip_active <= 1'b0;
        else if (state == POST)
            xip_active <= 1'b1;
    end
`else
    assign xip_active = 1'b0;
`endif

    // Next-state and phase counting
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 4'd1;
        bcnt_d  = bcnt;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (req) begin
                    state_d = PRE;
                    bcnt_d  = len;
                end
            end
            PRE: begin
                cnt_d   = '0;
                state_d = xip_active ? ADDR : CMD;
            end
            CMD:   if (cnt == 4'd7) begin state_d = ADDR;  cnt_d = '0; end
            ADDR:  if (cnt == 4'd5) begin state_d = MODE;  cnt_d = '0; end
            MODE:  if (cnt == 4'd1) begin state_d = DUMMY; cnt_d = '0; end
            DUMMY: if (cnt == DUMMY_LAST) begin state_d = DATA; cnt_d = '0; end
            DATA: begin
                if (cnt[0]) begin
                    cnt_d = '0;
                    if (bcnt == '0) state_d = POST;
                    else            bcnt_d  = bcnt - 1'b1;
                end
            end
            POST: begin
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: if (cnt == CSH_LAST) begin state_d = IDLE; cnt_d = '0; end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values for the upcoming cycle, decoded from the next state
    always_comb begin
        busy_d   = (state_d != IDLE);
        done_d   = (state == POST);
        spiss_d  = (state_d == CMD) || (state_d == ADDR) || (state_d == MODE) ||
                   (state_d == DUMMY) || (state_d == DATA);
        spiss2_d = (state_d != IDLE) && (state_d != GAP);
        spiz0_d  = 1'b1;
        spiz1_d  = 1'b1;
        spiout_d = 4'h0;
        bidx     = 3'd7 - cnt_d[2:0];
        unique case (state_d)
            CMD: begin
                spiz0_d     = 1'b0;
                spiout_d[0] = CMD_BYTE[bidx];
            end
            ADDR: begin
                spiz0_d = 1'b0;
                spiz1_d = 1'b0;
                unique case (cnt_d[2:0])
                    3'd0:    spiout_d = addr_q[23:20];
                    3'd1:    spiout_d = addr_q[19:16];
                    3'd2:    spiout_d = addr_q[15:12];
                    3'd3:    spiout_d = addr_q[11:8];
                    3'd4:    spiout_d = addr_q[7:4];
                    3'd5:    spiout_d = addr_q[3:0];
                    default: spiout_d = 4'h0;
                endcase
            end
            MODE: begin
                spiz0_d  = 1'b0;
                spiz1_d  = 1'b0;
                spiout_d = cnt_d[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
            end
            default: ;
        endcase
    end

    // Registered pin and status outputs
    always_ff @(posedge spiclk or negedge rstn) begin
        if (!rstn) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            spiss  <= 1'b0;
            spiss2 <= 1'b0;
            spiout <= 4'h0;
            spiz0  <= 1'b1;
            spiz1  <= 1'b1;
        end else begin
            busy   <= busy_d;
            done   <= done_d;
            spiss  <= spiss_d;
            spiss2 <= spiss2_d;
            spiout <= spiout_d;
            spiz0  <= spiz0_d;
            spiz1  <= spiz1_d;
        end
    end

    // Capture input nibbles at the closing edge of each DATA cycle
    always_ff @(posedge spiclk or negedge rstn) begin
        if (!rstn) begin
            hi_q     <= 4'h0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            rd_valid <= 1'b0;
            if (state == DATA) begin
                if (!cnt[0]) begin
                    hi_q <= spiin;
                end else begin
                    rd_valid <= 1'b1;
                    rd_data  <= {hi_q, spiin};
                end
            end
        end
    end

endmodule

// File: tb/tb_qspi_read_seq.sv
// Testbench for qspi_read_seq: directed reads against a nibble-level flash
// model, with a scoreboard queue checked by an independent monitor.
module tb_qspi_read_seq;

    localparam logic [7:0] CMD_BYTE  = 8'hEB;
    localparam int         DUMMY_CYC = 4;
    localparam int         CSH_CYC   = 2;
    localparam int         LEN_W     = 8;
`ifdef QSPI_XIP_EN
    localparam logic [7:0] EXP_MODE = 8'hA0;
`else
    localparam logic [7:0] EXP_MODE = 8'hFF;
`endif

    logic             spiclk = 1'b0;
    logic             rstn;
    logic             req;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic             busy, rd_valid, done, spiss, spiss2, spiz0, spiz1;
    logic [7:0]       rd_data;
    logic [3:0]       spiout, spiin;

    qspi_read_seq #(
        .CMD_BYTE(CMD_BYTE), .DUMMY_CYC(DUMMY_CYC), .CSH_CYC(CSH_CYC), .LEN_W(LEN_W)
    ) dut (
        .spiclk(spiclk), .rstn(rstn), .req(req), .addr(addr), .len(len),
        .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
        .spiss(spiss), .spiss2(spiss2), .spiout(spiout), .spiin(spiin),
        .spiz0(spiz0), .spiz1(spiz1)
    );

    always #5 spiclk = ~spiclk;

    int cyc = 0;
    always @(posedge spiclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out (cyc %0d)", nm, cyc);
    endtask

    // Scoreboard entries: byte value and the cycle stamp it must appear at
    typedef struct { logic [7:0] d; int c; } exp_t;
    exp_t       sbq[$];
    logic [7:0] fbytes[$];
    logic [23:0] exp_addr;
    int         exp_nib;
    logic       tb_xip = 1'b0;

    // Flash model: drives read nibbles, records what the DUT shifts out
    int          ss_cnt = 0, dir_err = 0;
    logic [7:0]  cmd_sh, mode_sh;
    logic [23:0] addr_sh;
    always @(negedge spiclk) begin
        int off, k, j;
        if (!rstn) begin
            ss_cnt = 0; dir_err = 0; tb_xip = 1'b0; spiin = 4'h0;
            cmd_sh = '0; addr_sh = '0; mode_sh = '0;
        end else begin
            off = tb_xip ? 0 : 8;
            if (spiss) begin
                k = ss_cnt - off;
                if (k < 0) begin
                    cmd_sh = {cmd_sh[6:0], spiout[0]};
                    if (spiout[3:1] != 3'b0 || spiz0 || !spiz1) dir_err++;
                end else if (k < 6) begin
                    addr_sh = {addr_sh[19:0], spiout};
                    if (spiz0 || spiz1) dir_err++;
                end else if (k < 8) begin
                    mode_sh = {mode_sh[3:0], spiout};
                    if (spiz0 || spiz1) dir_err++;
                end else if (!spiz0 || !spiz1) begin
                    dir_err++;
                end
                j = k - 8 - DUMMY_CYC;
                if (j >= 0 && j / 2 < fbytes.size())
                    spiin = (j % 2 == 0) ? fbytes[j/2][7:4] : fbytes[j/2][3:0];
                else
                    spiin = 4'h0;
                ss_cnt++;
            end else begin
                spiin = 4'h0;
                if (!spiz0 || !spiz1) dir_err++;
                if (ss_cnt != 0) begin
                    if (!tb_xip) chk("cmd_byte", cmd_sh, CMD_BYTE);
                    chk("addr_nibbles", addr_sh, exp_addr);
                    chk("mode_byte", mode_sh, EXP_MODE);
                    chk("spiss_cycles", ss_cnt, off + 8 + DUMMY_CYC + exp_nib);
                    chk("bus_dir", dir_err, 0);
                    ss_cnt  = 0;
                    dir_err = 0;
                end
            end
`ifdef QSPI_XIP_EN
            if (done) tb_xip = 1'b1;
`endif
        end
    end

    // Monitor: read data against the scoreboard, gap and select tracking
    int done_cnt = 0, last_gap = 0, glen = 0, s2_run = 0, n_rise = 0, min_low = 1000;
    logic gtrack = 1'b0, s2_prev = 1'b0;
    always @(negedge spiclk) begin
        exp_t e;
        if (!rstn) begin
            gtrack = 1'b0; s2_prev = 1'b0; s2_run = 0;
        end else begin
            if (rd_valid) begin
                if (sbq.size() == 0) begin
                    timeout("unexpected_rd_valid");
                end else begin
                    e = sbq.pop_front();
                    chk("rd_data", rd_data, e.d);
                    chk("rd_cycle", cyc, e.c);
                end
            end
            if (done) begin
                done_cnt++;
                gtrack = 1'b1;
                glen   = 1;
            end else if (gtrack) begin
                if (busy) glen++;
                else begin gtrack = 1'b0; last_gap = glen; end
            end
            if (spiss2 && !s2_prev) begin
                if (n_rise > 0 && s2_run < min_low) min_low = s2_run;
                n_rise++;
            end
            s2_run  = spiss2 ? 0 : s2_run + 1;
            s2_prev = spiss2;
        end
    end

    // Wait for the accept edge and load the expected bytes with their timing.
    // First byte is valid in cycle (1 PRE + CMD + 6 + 2 + DUMMY + 2) + 1
    // after accept; at the negedge of that cycle cyc = acc + that - 1.
    task automatic wait_accept(input int nbytes);
        int t = 0;
        int acc, off;
        do begin @(posedge spiclk); #1; t++; end while (!busy && t < 100);
        if (!busy) begin timeout("accept"); return; end
        acc = cyc;
        off = tb_xip ? 0 : 8;
        for (int i = 0; i < nbytes; i++) begin
            exp_t e;
            e.d = fbytes[i];
            e.c = acc + off + DUMMY_CYC + 11 + 2 * i;
            sbq.push_back(e);
        end
    endtask

    task automatic start_read(input logic [23:0] a, input logic [LEN_W-1:0] l);
        @(negedge spiclk);
        exp_addr = a;
        exp_nib  = 2 * (int'(l) + 1);
        addr = a; len = l; req = 1'b1;
        wait_accept(int'(l) + 1);
        req  = 1'b0;
        addr = ~a;                // must be ignored after accept
        len  = '1;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge spiclk); t++; end while ((busy || sbq.size() != 0) && t < 2000);
        if (busy || sbq.size() != 0) timeout("idle");
    endtask

    initial begin
        int t;
        rstn = 1'b0; req = 1'b0; addr = '0; len = '0;
        repeat (3) @(posedge spiclk);
        @(negedge spiclk);
        chk("reset_outputs", {busy, rd_valid, rd_data, done, spiss, spiss2, spiout, spiz0, spiz1},
            {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1});
        rstn = 1'b1;

        // 1: single byte read
        fbytes = '{8'h5A};
        done_cnt = 0;
        start_read(24'h123456, 8'd0);
        wait_idle();
        repeat (3) @(negedge spiclk);
        chk("done_pulses", done_cnt, 1);
        chk("gap_cycles", last_gap, CSH_CYC);

        // 2: four-byte burst
        fbytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        start_read(24'hABCDEF, 8'd3);
        wait_idle();

        // 3: reset during DATA, then a fresh read
        fbytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_read(24'h000100, 8'd3);
        t = 0;
        do begin @(negedge spiclk); t++; end while (!rd_valid && t < 100);
        if (!rd_valid) timeout("first_byte");
        #2 rstn = 1'b0;
        #1;
        chk("async_reset", {busy, rd_valid, rd_data, done, spiss, spiss2, spiout, spiz0, spiz1},
            {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1});
        sbq.delete();
        repeat (2) @(negedge spiclk);
        rstn = 1'b1;
        fbytes = '{8'h77};
        start_read(24'h654321, 8'd0);
        wait_idle();

        // 4: req held high across three reads
        fbytes = '{8'hC3, 8'h3C};
        n_rise = 0; min_low = 1000; done_cnt = 0;
        @(negedge spiclk);
        exp_addr = 24'hF0F0F0; exp_nib = 4;
        addr = 24'hF0F0F0; len = 8'd1; req = 1'b1;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) begin
                t = 0;
                do begin @(posedge spiclk); #1; t++; end while (busy && t < 200);
                if (busy) timeout("busy_drop");
            end
            wait_accept(2);
        end
        t = 0;
        do begin @(negedge spiclk); t++; end while (!done && t < 200);
        if (!done) timeout("third_done");
        req = 1'b0;
        wait_idle();
        repeat (10) @(negedge spiclk);
        chk("held_req_transactions", n_rise, 3);
        chk("held_req_done", done_cnt, 3);
        chk("cs_high_gap_min", min_low >= CSH_CYC, 1);

        // 6: back-to-back reads (continuous mode in the XIP build)
        fbytes = '{8'h9E, 8'hE9};
        start_read(24'h00ABCD, 8'd1);
        wait_idle();
        fbytes = '{8'h42};
        start_read(24'h00ABCF, 8'd0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

endmodule

// File: doc/qspi_read_seq.md
Name: qspi_read_seq

Overview:
Quad-SPI read sequencer that drives the flash pin-control bundle (spiss, spiss2, spiout, spiz0, spiz1, spiin) used by memhub on the spiclk domain. It accepts a read request (24-bit address, byte count) and runs the 0xEB Fast Read Quad I/O sequence. It streams received bytes out with a valid strobe, then enforces a chip-select high gap before accepting the next request. It is the sequencing engine behind the ADBus memory hub.

Parameters:
CMD_BYTE, 8'hEB, command opcode shifted out on IO0
DUMMY_CYC, 4, dummy clocks after the mode byte (range 1..15)
CSH_CYC, 2, minimum cycles with spiss2 low between transactions (range 1..15)
LEN_W, 8, width of the length field

Ports:
spiclk  in  1  sequencer clock; SCK = ~spiclk & spiss is generated at top level
rstn  in  1  asynchronous active-low reset
req  in  1  start request; sampled only in IDLE
addr  in  24  flash byte address; latched on accept
len  in  LEN_W  bytes to read minus one; latched on accept
busy  out  1  high from accept edge until return to IDLE
rd_valid  out  1  one-cycle strobe per received byte
rd_data  out  8  received byte; valid while rd_valid is high
done  out  1  one-cycle pulse on entry to GAP
spiss  out  1  narrow select; gates SCK; high in CMD..DATA only
spiss2  out  1  wide select; drives the flash CS# pin (inverted at top)
spiout  out  4  flash output nibble
spiin  in  4  flash input nibble
spiz0  out  1  IO0 output enable, active-low (1 = tristate)
spiz1  out  1  IO1..IO3 output enable, active-low

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - State = IDLE.
  - busy=0, rd_valid=0, rd_data=0, done=0, spiss=0, spiss2=0, spiout=0, spiz0=1, spiz1=1.
  - All counters and shift registers cleared.
- All outputs are registered. Each state's cycle count is listed below:
  - IDLE: on req=1, latch addr/len, set busy=1, go to PRE.
  - PRE (1 cycle): spiss2=1, spiss=0, IO tristated.
  - CMD (8 cycles): spiss=1, spiz0=0, spiz1=1. spiout[0] carries CMD_BYTE MSB first. spiout[3:1]=0.
  - ADDR (6 cycles): spiz0=spiz1=0. spiout carries addr[23:20] first, then addr[3:0] last.
  - MODE (2 cycles): outputs mode byte 8'hFF, high nibble first.
  - DUMMY (DUMMY_CYC cycles): spiz0=spiz1=1.
  - DATA (2 cycles per byte): IO tristated.
    - spiin is sampled at the closing edge of each cycle: high nibble first, then low nibble.
    - rd_valid and rd_data assert in the cycle after the low-nibble sample.
    - Byte counter counts down from len; when it reaches 0 after the last byte, go to POST.
  - POST (1 cycle): spiss=0, spiss2=1.
  - GAP (CSH_CYC cycles): spiss2=0. done pulses in the first GAP cycle. After the gap, busy=0 and state returns to IDLE.
- req asserted while busy is ignored; no queueing.
- Requests are accepted back-to-back: a new req can be accepted on the first IDLE cycle.
- The address is not incremented by the sequencer; the flash auto-increments within a burst.
- len is all-ones: reads 2^LEN_W bytes. There is no zero-length read.
- addr and len changing after accept have no effect.
- Latency, DUMMY_CYC=4, measured from the accept edge: first rd_valid is high 24 cycles later. Each following byte arrives 2 cycles after the previous one.

Optional Feature:
Macro: QSPI_XIP_EN
- When defined:
  - Mode byte is 8'hA0 (continuous read).
  - A 1-bit xip_active register is set at the end of the first completed transaction.
  - While xip_active=1, PRE goes directly to ADDR; the CMD phase is skipped, saving 8 cycles (first byte at 16 cycles).
  - Reset clears xip_active.
- When not defined:
  - Mode byte is 8'hFF.
  - CMD is sent on every transaction and there is no xip_active state.

Test Plan:
1. Reset then req with addr=24'h123456, len=0 -> IO0 carries 8'hEB MSB first. IO nibbles are 1,2,3,4,5,6 then F,F. The flash model returns 8'h5A, giving rd_valid once with rd_data=8'h5A, 24 cycles after accept. done pulses, and spiss2 is low for 2 cycles.
2. len=3, model returns 8'h01,8'h02,8'h03,8'h04 -> four rd_valid strobes exactly 2 cycles apart with those values. spiss drops after the 4th low nibble.
3. Assert rstn=0 during DATA of a 4-byte read -> all outputs take reset values immediately. A new req after release starts again with a full CMD phase.
4. Hold req=1 continuously for 3 reads -> each accept occurs only in IDLE. spiss2 is low for at least CSH_CYC cycles between transactions, and there are no extra transactions.
5. Check bus direction across a full transaction -> spiz0=0 only in CMD/ADDR/MODE, spiz1=0 only in ADDR/MODE, and both are 1 in DUMMY/DATA.
6. QSPI_XIP_EN defined, two back-to-back reads -> the first read sends 8'hEB with mode nibbles A,0. The second read has no CMD phase, and its first rd_valid arrives 16 cycles after accept.
